// File: rtl/boolean_sweep_ctrl_pkg.sv
// Shared definitions for the Boolean truth-table sweep controller.
package boolean_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int unsigned N_IN_DEFAULT = 3;

    // vec_out bit order: A is the MSB, C the LSB.
    localparam int unsigned VEC_A_BIT = 2;
    localparam int unsigned VEC_B_BIT = 1;
    localparam int unsigned VEC_C_BIT = 0;

    function automatic int unsigned n_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/boolean_sweep_ctrl_settle_timer.sv
// Loadable down counter that times how long each vector is held before F is sampled.
module settle_timer
    import boolean_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic cnt_zero_o
);

    localparam int unsigned W = $clog2(SETTLE_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: reload takes priority, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(SETTLE_CYCLES - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/boolean_sweep_ctrl.sv
// Walks every input vector of the Boolean datapath, captures F into a truth table
// and compares it against a golden table latched at start.
module boolean_sweep_ctrl
    import boolean_sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IN          = N_IN_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    input  logic                  f_in,
    output logic [N_IN-1:0]       vec_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(1<<N_IN)-1:0]  truth_out,
    output logic [N_IN-1:0]       fail_idx,
    output logic [N_IN:0]         fail_count
);

    localparam int unsigned N_VEC = n_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_VEC-1:0]  exp_q, exp_d;
    logic [N_VEC-1:0]  truth_q, truth_d;
    logic [N_IN-1:0]   fidx_q, fidx_d;
    logic [N_IN:0]     fcnt_q, fcnt_d;
    logic              pass_q, pass_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .cnt_zero_o (tmr_zero)
    );

    // Sweep sequencing, sampling and mismatch bookkeeping.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        truth_d  = truth_q;
        fidx_d   = fidx_q;
        fcnt_d   = fcnt_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    idx_d    = '0;
                    truth_d  = '0;
                    fidx_d   = '0;
                    fcnt_d   = '0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = S_DRIVE;
                end
            end

            S_DRIVE: begin
                if (tmr_zero) begin
                    state_d = S_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            S_SAMPLE: begin
                truth_d[idx_q] = f_in;
                if (f_in != exp_q[idx_q]) begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (fcnt_q == '0) begin
                        fidx_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // Verdict is registered with the last sample so it is valid during DONE.
                    pass_d  = (fcnt_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = S_DRIVE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            truth_q <= '0;
            fidx_q  <= '0;
            fcnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            truth_q <= truth_d;
            fidx_q  <= fidx_d;
            fcnt_q  <= fcnt_d;
            pass_q  <= pass_d;
        end
    end

    // Datapath drive and status decode.
    always_comb begin
        busy    = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
        done    = (state_q == S_DONE);
        vec_out = busy ? idx_q : '0;
    end

    assign pass       = pass_q;
    assign truth_out  = truth_q;
    assign fail_idx   = fidx_q;
    assign fail_count = fcnt_q;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Scoreboard bench for boolean_sweep_ctrl with SETTLE_CYCLES=1 and SETTLE_CYCLES=3 instances.
module tb_boolean_sweep_ctrl;

    typedef struct {
        int unsigned dut;
        int unsigned kcyc;
        logic        pass;
        logic [7:0]  truth;
        logic [2:0]  fidx;
        logic [3:0]  fcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    exp_t        last_res[2];
    int unsigned vec_bad[2];

    logic        start_s[2];
    logic [7:0]  exp_s[2];
    logic        f_s[2];
    logic [2:0]  vec_s[2];
    logic        busy_s[2];
    logic        done_s[2];
    logic        pass_s[2];
    logic [7:0]  truth_s[2];
    logic [2:0]  fidx_s[2];
    logic [3:0]  fcnt_s[2];

    // Boolean datapath under test: F = A&B | ~C.
    assign f_s[0] = (vec_s[0][2] & vec_s[0][1]) | ~vec_s[0][0];
    assign f_s[1] = (vec_s[1][2] & vec_s[1][1]) | ~vec_s[1][0];

    boolean_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .expected(exp_s[0]), .f_in(f_s[0]),
        .vec_out(vec_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .truth_out(truth_s[0]), .fail_idx(fidx_s[0]), .fail_count(fcnt_s[0])
    );

    boolean_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start_s[1]), .expected(exp_s[1]), .f_in(f_s[1]),
        .vec_out(vec_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .truth_out(truth_s[1]), .fail_idx(fidx_s[1]), .fail_count(fcnt_s[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned settle(input int unsigned d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic f_ref(input int unsigned i);
        logic a, b, c;
        a = ((i >> 2) & 1) != 0;
        b = ((i >> 1) & 1) != 0;
        c = (i & 1) != 0;
        return (a & b) | ~c;
    endfunction

    // Expected sweep outcome derived directly from the truth-table rules.
    function automatic exp_t model(input int unsigned d, input int unsigned k, input logic [7:0] e);
        exp_t r;
        int unsigned cnt = 0;
        bit found = 0;
        r.dut   = d;
        r.kcyc  = k;
        r.truth = '0;
        r.fidx  = '0;
        for (int i = 0; i < 8; i++) begin
            r.truth[i] = f_ref(i);
            if (r.truth[i] != e[i]) begin
                cnt++;
                if (!found) begin
                    r.fidx = 3'(i);
                    found  = 1;
                end
            end
        end
        r.fcnt = 4'(cnt);
        r.pass = (cnt == 0);
        return r;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int unsigned d);
        chk("reset_outputs",
            {11'd0, vec_s[d], busy_s[d], done_s[d], pass_s[d], truth_s[d], fidx_s[d], fcnt_s[d]}, 0);
    endtask

    task automatic wait_idle(input int unsigned d);
        int n = 0;
        while ((busy_s[d] || done_s[d]) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
    endtask

    task automatic start_sweep(input int unsigned d, input logic [7:0] e);
        exp_t r;
        wait_idle(d);
        exp_s[d]   = e;
        start_s[d] = 1'b1;
        step();
        start_s[d] = 1'b0;
        r = model(d, cyc, e);
        sbq.push_back(r);
        last_res[d] = r;
    endtask

    task automatic wait_done(input int unsigned d);
        int n = 0;
        while (!done_s[d] && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("done_timeout", 0, 1);
    endtask

    task automatic check_hold(input int unsigned d);
        repeat (3) step();
        exp_s[d] = 8'($urandom);
        step();
        chk("hold_pass",  pass_s[d],  last_res[d].pass);
        chk("hold_truth", truth_s[d], last_res[d].truth);
        chk("hold_fidx",  fidx_s[d],  last_res[d].fidx);
        chk("hold_fcnt",  fcnt_s[d],  last_res[d].fcnt);
    endtask

    // Monitor: tracks the vector walk and scores every done pulse against the queue.
    always @(negedge clk) begin
        int unsigned t;
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (busy_s[d]) begin
                    if (sbq.size() > 0 && sbq[0].dut == d) begin
                        t = cyc - sbq[0].kcyc;
                        if (vec_s[d] != 3'(t / (settle(d) + 1))) vec_bad[d]++;
                    end else begin
                        vec_bad[d]++;
                    end
                end else if (vec_s[d] != 3'd0) begin
                    vec_bad[d]++;
                end

                if (done_s[d]) begin
                    if (sbq.size() == 0 || sbq[0].dut != d) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("latency",    cyc - e.kcyc, 8 * (settle(d) + 1));
                        chk("pass",       pass_s[d],  e.pass);
                        chk("truth_out",  truth_s[d], e.truth);
                        chk("fail_idx",   fidx_s[d],  e.fidx);
                        chk("fail_count", fcnt_s[d],  e.fcnt);
                        chk("busy_at_done", busy_s[d], 0);
                        chk("vec_walk_errors", vec_bad[d], 0);
                        vec_bad[d] = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] e;
        start_s = '{1'b0, 1'b0};
        exp_s   = '{8'h00, 8'h00};
        vec_bad = '{0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        step();

        // Golden table matches.
        start_sweep(0, 8'hD5);
        wait_done(0);
        check_hold(0);

        // Reset while idle with results held.
        rst = 1'b1;
        #1;
        chk_zero(0);
        chk_zero(1);
        step();
        rst = 1'b0;
        step();

        // Single mismatch, then every bit wrong.
        start_sweep(0, 8'hD4);
        wait_done(0);
        check_hold(0);
        start_sweep(0, 8'h2A);
        wait_done(0);
        check_hold(0);

        // Start and expected changes during a sweep are ignored.
        e = 8'($urandom);
        start_sweep(0, e);
        repeat (5) step();
        exp_s[0]   = ~e;
        start_s[0] = 1'b1;
        repeat (3) step();
        start_s[0] = 1'b0;
        wait_done(0);
        repeat (20) step();
        check_hold(0);

        // Abort in SAMPLE of vector 4, then a clean sweep.
        start_sweep(0, 8'hD5);
        repeat (9) step();
        chk("vec_before_abort", vec_s[0], 4);
        rst = 1'b1;
        #1;
        chk_zero(0);
        sbq.delete();
        vec_bad = '{0, 0};
        step();
        rst = 1'b0;
        repeat (2) step();
        start_sweep(0, 8'hD5);
        wait_done(0);
        check_hold(0);

        // Random tables on both instances.
        for (int i = 0; i < 6; i++) begin
            int unsigned d;
            d = i % 2;
            start_sweep(d, 8'($urandom));
            wait_done(d);
            check_hold(d);
        end

        // Longer settle time.
        start_sweep(1, 8'hD5);
        wait_done(1);
        check_hold(1);

        repeat (5) step();
        chk("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
